led_frame_stager: RTL and testbench
===================================

// Module: led_frame_stager
// PURPOSE
//   Upstream feeder for the serial LED driver. Accepts CPU-side pattern writes
//   into a shadow register and commits them to the driver's 16-bit parallel
//   input only at a frame boundary, which is the rising edge of the driver's
//   latch strobe, so the driver never shifts out a torn frame.
//   Also applies per-bit blinking, toggled every BLINK_FRAMES frames.
// PARAMETERS
//   RESET_PATTERN  16'h0000  active and shadow data value after reset
//   BLINK_FRAMES   8         latch rising edges per blink half-period (>=1)
// PORTS
//   i_CLK        in   1   system clock, all logic on rising edge
//   i_RESET      in   1   synchronous reset, active-high
//   i_WrValid    in   1   write request
//   o_WrReady    out  1   write accepted when i_WrValid & o_WrReady at edge
//   i_WrSel      in   1   0 = pattern data, 1 = blink mask
//   i_WrByteEn   in   2   bit0 -> [7:0], bit1 -> [15:8]
//   i_WrData     in   16  write data
//   i_LEDLatch   in   1   latch strobe from LED driver (frame boundary)
//   o_Data16     out  16  parallel pattern to LED driver
//   o_Pending    out  1   shadow holds data not yet committed
//   o_BlinkPhase out  1   1 = blinking bits visible, 0 = blanked
// BEHAVIOUR
//   Interface: one clock, i_CLK. Reset i_RESET is synchronous and active-high.
//   Reset: state IDLE; shadow and active data = RESET_PATTERN; shadow and
//     active mask = 0; frame counter = 0; o_BlinkPhase = 1; latch_q = 0.
//     o_WrReady = 0 while i_RESET is high.
//   Frame edge: fe = i_LEDLatch & ~latch_q. latch_q is registered every cycle.
//     A multi-cycle-high latch strobe counts once.
//   Write: an accepted write updates the enabled bytes of the shadow data
//     (i_WrSel = 0) or the shadow mask (i_WrSel = 1).
//     i_WrByteEn = 0 is accepted as a no-op but still sets pending.
//   FSM:
//     IDLE:    accepted write -> PENDING. fe is ignored for commit.
//     PENDING: fe -> COMMIT. Writes keep being accepted.
//              A write on the same edge as fe is captured and committed.
//     COMMIT:  lasts one cycle. o_WrReady = 0. At the next edge, active data
//              and mask <= shadow; state -> IDLE.
//   Commit rule: a write on the same edge as fe while in IDLE does NOT commit
//     on that fe. It waits for the next frame edge.
//   Latency: fe sampled at edge N -> COMMIT during cycle N..N+1 -> new
//     o_Data16 visible after edge N+1.
//   o_WrReady = ~i_RESET & (state != COMMIT). o_Pending = (state != IDLE).
//   Blink: every fe (any state) increments the frame counter. At
//     BLINK_FRAMES-1 it wraps to 0 and toggles o_BlinkPhase.
//     Counter width is $clog2(BLINK_FRAMES+1).
//   Output: o_Data16 = active_data & ~(active_mask & {16{~o_BlinkPhase}}).
//     This is combinational from registers only, with no input-to-output path.
//   Reset mid-operation: pending shadow contents are discarded. The next
//     frame shows RESET_PATTERN.
// TESTING
//   1 Reset held 3 cycles, RESET_PATTERN=0 -> o_Data16=0000, o_WrReady=0
//     during reset and 1 after, o_Pending=0, o_BlinkPhase=1.
//   2 Write 16'h4886, ByteEn=11, then 10 idle cycles -> o_Data16 stays 0000,
//     o_Pending=1. Pulse i_LEDLatch for 1 cycle at edge N -> o_WrReady=0 for
//     cycle N..N+1, o_Data16=4886 after edge N+1, o_Pending=0.
//   3 Active data = 4886. Write data AB12 with ByteEn=01, commit -> 4812.
//     Then write CD00 with ByteEn=10, commit -> CD12.
//   4 Data FFFF, mask 00FF, BLINK_FRAMES=2: 2 frame edges -> o_Data16=FF00,
//     phase=0. 2 more -> FFFF. i_LEDLatch held high 5 cycles counts as 1 edge.
//   5 Simultaneous events. In IDLE, write 1234 on the same edge as fe ->
//     no commit, o_Pending=1, commit on the next fe. In PENDING, write 5678 on
//     the fe edge -> committed value 5678.
//   6 Write AAAA (pending), assert i_RESET 1 cycle, then fe -> o_Data16 =
//     RESET_PATTERN, o_Pending=0.

Source files
------------

// File: rtl/led_frame_stager.sv
// Shadow/active pattern stager for the serial LED driver.
// Commits CPU writes on latch-strobe rising edges and applies per-bit blinking.
module led_frame_stager #(
  parameter logic [15:0] RESET_PATTERN = 16'h0000,
  parameter int          BLINK_FRAMES  = 8
) (
  input  logic        i_CLK,
  input  logic        i_RESET,
  input  logic        i_WrValid,
  output logic        o_WrReady,
  input  logic        i_WrSel,
  input  logic [1:0]  i_WrByteEn,
  input  logic [15:0] i_WrData,
  input  logic        i_LEDLatch,
  output logic [15:0] o_Data16,
  output logic        o_Pending,
  output logic        o_BlinkPhase
);

  localparam int CW = $clog2(BLINK_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     sh_data_q, sh_data_d;
  logic [15:0]     sh_mask_q, sh_mask_d;
  logic [15:0]     act_data_q, act_data_d;
  logic [15:0]     act_mask_q, act_mask_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            phase_q, phase_d;
  logic            latch_q, latch_d;

  logic            fe;
  logic            wr_acc;
  logic            commit_en;
  logic [15:0]     be_mask;

  assign fe      = i_LEDLatch & ~latch_q;
  assign wr_acc  = i_WrValid & o_WrReady;
  assign be_mask = {{8{i_WrByteEn[1]}}, {8{i_WrByteEn[0]}}};

  // State and datapath registers
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_q    <= IDLE;
      sh_data_q  <= RESET_PATTERN;
      sh_mask_q  <= '0;
      act_data_q <= RESET_PATTERN;
      act_mask_q <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b1;
      latch_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_data_q  <= sh_data_d;
      sh_mask_q  <= sh_mask_d;
      act_data_q <= act_data_d;
      act_mask_q <= act_mask_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      latch_q    <= latch_d;
    end
  end

  // Next state: a frame edge only commits once data is already pending
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (wr_acc) state_d = PENDING;
      PENDING: if (fe) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_WrReady = ~i_RESET & (state_q != COMMIT);
    o_Pending = (state_q != IDLE);
    commit_en = (state_q == COMMIT);
  end

  // Shadow capture, active commit and blink counter
  always_comb begin
    sh_data_d  = sh_data_q;
    sh_mask_d  = sh_mask_q;
    act_data_d = act_data_q;
    act_mask_d = act_mask_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    latch_d    = i_LEDLatch;
    if (wr_acc) begin
      if (i_WrSel)
        sh_mask_d = (sh_mask_q & ~be_mask) | (i_WrData & be_mask);
      else
        sh_data_d = (sh_data_q & ~be_mask) | (i_WrData & be_mask);
    end
    if (commit_en) begin
      act_data_d = sh_data_q;
      act_mask_d = sh_mask_q;
    end
    if (fe) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Blank masked bits during the off phase
  always_comb begin
    o_BlinkPhase = phase_q;
    o_Data16     = act_data_q & ~(act_mask_q & {16{~phase_q}});
  end

endmodule

// File: tb/tb_led_frame_stager.sv
// Scoreboard bench for led_frame_stager: a frame-level model queues the
// expected outputs per cycle, a monitor pops and compares on the falling edge.
module tb_led_frame_stager;

  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic        wr_sel = 1'b0;
  logic [1:0]  wr_be = 2'b00;
  logic [15:0] wr_data = 16'h0;
  logic        latch = 1'b0;
  logic [15:0] data16;
  logic        pending;
  logic        phase;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] data;
    logic        pend;
    logic        phase;
    logic        commit;
  } exp_t;

  exp_t exp_q[$];

  // model state
  logic [15:0] m_shadow, m_smask, m_active, m_amask;
  bit          m_waiting;
  bit          m_commit;
  bit          m_latch;
  int          m_frames;

  led_frame_stager #(
    .RESET_PATTERN(16'h0000),
    .BLINK_FRAMES (BF)
  ) dut (
    .i_CLK       (clk),
    .i_RESET     (rst),
    .i_WrValid   (wr_valid),
    .o_WrReady   (wr_ready),
    .i_WrSel     (wr_sel),
    .i_WrByteEn  (wr_be),
    .i_WrData    (wr_data),
    .i_LEDLatch  (latch),
    .o_Data16    (data16),
    .o_Pending   (pending),
    .o_BlinkPhase(phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old,
                                        input logic [15:0] nw,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = old;
    for (int b = 0; b < 2; b++)
      if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // One clock of the frame-level model, applied to the inputs of this edge
  task automatic model_edge();
    bit   fe, acc, was_wait, was_commit;
    exp_t e;
    bit   ph;
    if (rst) begin
      m_shadow = 16'h0; m_smask = 16'h0;
      m_active = 16'h0; m_amask = 16'h0;
      m_waiting = 0; m_commit = 0; m_latch = 0; m_frames = 0;
    end else begin
      fe = latch && !m_latch;
      m_latch = latch;
      was_wait = m_waiting;
      was_commit = m_commit;
      acc = wr_valid && !was_commit;
      if (was_commit) begin
        m_active = m_shadow;
        m_amask  = m_smask;
        m_commit = 0;
      end
      if (acc) begin
        if (wr_sel) m_smask = merge(m_smask, wr_data, wr_be);
        else        m_shadow = merge(m_shadow, wr_data, wr_be);
      end
      if (was_wait && fe) begin
        m_waiting = 0;
        m_commit = 1;
      end else if (acc && !was_wait) begin
        m_waiting = 1;
      end
      if (fe) m_frames++;
    end
    ph = ((m_frames / BF) % 2) == 0;
    e.phase  = ph;
    e.data   = m_active & ~(m_amask & {16{~ph}});
    e.pend   = m_waiting || m_commit;
    e.commit = m_commit;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit v, input bit s, input logic [1:0] be,
                       input logic [15:0] d, input bit l, input bit r);
    wr_valid = v; wr_sel = s; wr_be = be; wr_data = d;
    latch = l; rst = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 2'b00, 16'h0, 0, 0);
  endtask

  // Monitor: compare DUT against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("mon_data", data16, e.data);
        check("mon_pending", {15'h0, pending}, {15'h0, e.pend});
        check("mon_phase", {15'h0, phase}, {15'h0, e.phase});
        check("mon_ready", {15'h0, wr_ready},
              {15'h0, ~rst & ~e.commit});
      end
    end
  end

  initial begin
    // 1: reset
    drive(0, 0, 2'b00, 16'h0, 0, 1);
    drive(0, 0, 2'b00, 16'h0, 0, 1);
    check("t1_ready_in_reset", {15'h0, wr_ready}, 16'h0);
    drive(0, 0, 2'b00, 16'h0, 0, 1);
    idle(1);
    check("t1_data", data16, 16'h0000);
    check("t1_ready", {15'h0, wr_ready}, 16'h1);
    check("t1_pending", {15'h0, pending}, 16'h0);
    check("t1_phase", {15'h0, phase}, 16'h1);

    // 2: write then commit on a one-cycle latch pulse
    drive(1, 0, 2'b11, 16'h4886, 0, 0);
    idle(10);
    check("t2_hold_data", data16, 16'h0000);
    check("t2_hold_pending", {15'h0, pending}, 16'h1);
    drive(0, 0, 2'b00, 16'h0, 1, 0);
    check("t2_commit_ready", {15'h0, wr_ready}, 16'h0);
    idle(1);
    check("t2_data", data16, 16'h4886);
    check("t2_pending", {15'h0, pending}, 16'h0);

    // 3: byte enables
    drive(1, 0, 2'b01, 16'hAB12, 0, 0);
    drive(0, 0, 2'b00, 16'h0, 1, 0);
    idle(1);
    check("t3_low_byte", data16, 16'h4812);
    drive(1, 0, 2'b10, 16'hCD00, 0, 0);
    drive(0, 0, 2'b00, 16'h0, 1, 0);
    idle(1);
    check("t3_high_byte", data16, 16'hCD12);

    // 4: blinking with BF = 2
    drive(0, 0, 2'b00, 16'h0, 0, 1);
    drive(1, 0, 2'b11, 16'hFFFF, 0, 0);
    drive(1, 1, 2'b11, 16'h00FF, 0, 0);
    drive(0, 0, 2'b00, 16'h0, 1, 0);
    idle(2);
    check("t4_after1", data16, 16'hFFFF);
    drive(0, 0, 2'b00, 16'h0, 1, 0);
    idle(1);
    check("t4_blank", data16, 16'hFF00);
    check("t4_phase0", {15'h0, phase}, 16'h0);
    for (int i = 0; i < 5; i++) drive(0, 0, 2'b00, 16'h0, 1, 0);
    idle(1);
    check("t4_long_latch", data16, 16'hFF00);
    drive(0, 0, 2'b00, 16'h0, 1, 0);
    idle(1);
    check("t4_unblank", data16, 16'hFFFF);
    check("t4_phase1", {15'h0, phase}, 16'h1);

    // 5: write coinciding with frame edge
    drive(0, 0, 2'b00, 16'h0, 0, 1);
    drive(1, 0, 2'b11, 16'h1234, 1, 0);
    check("t5_idle_fe_pending", {15'h0, pending}, 16'h1);
    check("t5_idle_fe_ready", {15'h0, wr_ready}, 16'h1);
    idle(1);
    check("t5_no_commit", data16, 16'h0000);
    drive(0, 0, 2'b00, 16'h0, 1, 0);
    idle(1);
    check("t5_late_commit", data16, 16'h1234);
    drive(1, 0, 2'b11, 16'h1111, 0, 0);
    drive(1, 0, 2'b11, 16'h5678, 1, 0);
    idle(1);
    check("t5_same_edge", data16, 16'h5678);

    // 6: reset discards pending shadow
    drive(1, 0, 2'b11, 16'hAAAA, 0, 0);
    drive(0, 0, 2'b00, 16'h0, 0, 1);
    drive(0, 0, 2'b00, 16'h0, 1, 0);
    idle(1);
    check("t6_data", data16, 16'h0000);
    check("t6_pending", {15'h0, pending}, 16'h0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit l;
      l = ($urandom_range(0, 99) < 60) ? latch : ($urandom_range(0, 4) == 0);
      drive($urandom_range(0, 1), $urandom_range(0, 1),
            2'($urandom_range(0, 3)), 16'($urandom),
            l, $urandom_range(0, 99) < 2);
    end
    idle(2);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
